// File: rtl/snoop_response_gen_pkg.sv
// Shared types for the LLC snoop path: bus ops, MESI states and snoop results.
// Also used by the put-snoop-result reporter.
package snoop_response_gen_pkg;

   localparam int unsigned ADDRESS_SIZE_DEF = 32;
   localparam int unsigned INDEX_BITS_DEF   = 14;
   localparam int unsigned OFFSET_BITS_DEF  = 6;

   typedef enum logic [1:0] {
      BUS_READ       = 2'b00,
      BUS_WRITE      = 2'b01,
      BUS_INVALIDATE = 2'b10,
      BUS_RWIM       = 2'b11
   } bus_op_t;

   typedef enum logic [1:0] {
      MESI_I = 2'b00,
      MESI_S = 2'b01,
      MESI_E = 2'b10,
      MESI_M = 2'b11
   } mesi_t;

   typedef enum logic [1:0] {
      SNP_HIT   = 2'b00,
      SNP_HITM  = 2'b01,
      SNP_NOHIT = 2'b10
   } snoop_result_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/snoop_response_gen_resolve.sv
// Combinational snoop resolution: maps {op, hit, mesi} to result, new state,
// write-back and protocol-error flags.
module snoop_resolve
   import snoop_response_gen_pkg::*;
(
   input  logic       hit,
   input  logic [1:0] op,
   input  logic [1:0] mesi,
   output logic [1:0] result,
   output logic [1:0] new_mesi,
   output logic       wr,
   output logic       wb,
   output logic       err
);

   logic valid_hit;

   always_comb begin
      valid_hit = hit && (mesi != MESI_I);
      result    = SNP_NOHIT;
      new_mesi  = mesi;
      wb        = 1'b0;
      err       = 1'b0;
      if (valid_hit) begin
         case (op)
            BUS_READ: begin
               new_mesi = MESI_S;
               result   = (mesi == MESI_M) ? SNP_HITM : SNP_HIT;
               wb       = (mesi == MESI_M);
            end
            BUS_INVALIDATE: begin
               // A plain invalidate is only legal against a Shared copy.
               if (mesi == MESI_S) begin
                  new_mesi = MESI_I;
                  result   = SNP_HIT;
               end else begin
                  err = 1'b1;
               end
            end
            BUS_RWIM: begin
               new_mesi = MESI_I;
               result   = (mesi == MESI_M) ? SNP_HITM : SNP_HIT;
               wb       = (mesi == MESI_M);
            end
            default: ;
         endcase
      end
      wr = valid_hit && (new_mesi != mesi);
   end

endmodule

// File: rtl/snoop_response_gen.sv
// Snoop response generator: tag lookup, MESI downgrade and result handoff.
// Optional SNOOP_STATS_EN adds saturating snoop/result counters.
module snoop_response_gen
   import snoop_response_gen_pkg::*;
#(
   parameter int unsigned ADDRESS_SIZE = ADDRESS_SIZE_DEF,
   parameter int unsigned INDEX_BITS   = INDEX_BITS_DEF,
   parameter int unsigned OFFSET_BITS  = OFFSET_BITS_DEF,
   parameter int unsigned WAYS         = 16,
   parameter int unsigned LOOKUP_LAT   = 1,
   localparam int unsigned WayW        = $clog2(WAYS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    snp_valid,
   output logic                    snp_ready,
   input  logic [1:0]              snp_op,
   input  logic [ADDRESS_SIZE-1:0] snp_addr,
   output logic                    tag_rd_en,
   output logic [ADDRESS_SIZE-1:0] tag_rd_addr,
   input  logic                    tag_hit,
   input  logic [WayW-1:0]         tag_way,
   input  logic [1:0]              tag_mesi,
   output logic                    tag_wr_en,
   output logic [WayW-1:0]         tag_wr_way,
   output logic [1:0]              tag_wr_mesi,
   output logic                    wb_req,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [ADDRESS_SIZE-1:0] res_addr,
   output logic [1:0]              res_result,
   output logic                    proto_err
`ifdef SNOOP_STATS_EN
   ,
   output logic [31:0]             snoop_reads,
   output logic [31:0]             snoop_rwims,
   output logic [31:0]             snoop_invals,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             hitm_cnt,
   output logic [31:0]             nohit_cnt
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOOKUP  = 2'd1;
   localparam logic [1:0] ST_RESOLVE = 2'd2;
   localparam logic [1:0] ST_REPORT  = 2'd3;

   localparam int unsigned TagLsb = INDEX_BITS + OFFSET_BITS;

   logic [1:0]              state;
   logic [1:0]              op_q;
   logic [ADDRESS_SIZE-1:0] addr_q;
   logic [1:0]              lat_cnt;
   logic                    res_valid_q;
   logic [ADDRESS_SIZE-1:0] res_addr_q;
   logic [1:0]              res_result_q;
   logic                    proto_err_q;

   logic [1:0] rs_result;
   logic [1:0] rs_new_mesi;
   logic       rs_wr;
   logic       rs_wb;
   logic       rs_err;

   // Tag data is live during RESOLVE, LOOKUP_LAT cycles after the strobe.
   snoop_resolve u_resolve (
      .hit      (tag_hit),
      .op       (op_q),
      .mesi     (tag_mesi),
      .result   (rs_result),
      .new_mesi (rs_new_mesi),
      .wr       (rs_wr),
      .wb       (rs_wb),
      .err      (rs_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         op_q         <= BUS_READ;
         addr_q       <= '0;
         lat_cnt      <= 2'd0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         res_result_q <= SNP_NOHIT;
         proto_err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (snp_valid) begin
                  op_q    <= snp_op;
                  addr_q  <= snp_addr;
                  lat_cnt <= 2'd0;
                  state   <= (snp_op == BUS_WRITE) ? ST_RESOLVE : ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (lat_cnt == 2'(LOOKUP_LAT - 1)) begin
                  state <= ST_RESOLVE;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            ST_RESOLVE: begin
               res_addr_q   <= addr_q;
               res_result_q <= rs_result;
               res_valid_q  <= 1'b1;
               if (rs_err) begin
                  proto_err_q <= 1'b1;
               end
               state <= ST_REPORT;
            end
            default: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Strobes are gated by rst_n so a reset during RESOLVE issues nothing.
   always_comb begin
      snp_ready   = (state == ST_IDLE);
      tag_rd_en   = rst_n && (state == ST_LOOKUP) && (lat_cnt == 2'd0);
      tag_rd_addr = {addr_q[ADDRESS_SIZE-1:TagLsb], addr_q[TagLsb-1:OFFSET_BITS],
                     {OFFSET_BITS{1'b0}}};
      tag_wr_en   = rst_n && (state == ST_RESOLVE) && rs_wr;
      tag_wr_way  = tag_way;
      tag_wr_mesi = rs_new_mesi;
      wb_req      = rst_n && (state == ST_RESOLVE) && rs_wb;
      res_valid   = res_valid_q;
      res_addr    = res_addr_q;
      res_result  = res_result_q;
      proto_err   = proto_err_q;
   end

`ifdef SNOOP_STATS_EN
   logic resolving;
   assign resolving = (state == ST_RESOLVE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snoop_reads  <= '0;
         snoop_rwims  <= '0;
         snoop_invals <= '0;
         hit_cnt      <= '0;
         hitm_cnt     <= '0;
         nohit_cnt    <= '0;
      end else if (resolving) begin
         if (op_q == BUS_READ)           snoop_reads  <= sat_inc(snoop_reads);
         if (op_q == BUS_RWIM)           snoop_rwims  <= sat_inc(snoop_rwims);
         if (op_q == BUS_INVALIDATE)     snoop_invals <= sat_inc(snoop_invals);
         if (rs_result == SNP_HIT)       hit_cnt      <= sat_inc(hit_cnt);
         if (rs_result == SNP_HITM)      hitm_cnt     <= sat_inc(hitm_cnt);
         if (rs_result == SNP_NOHIT)     nohit_cnt    <= sat_inc(nohit_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_snoop_response_gen.sv
// Directed self-checking bench for snoop_response_gen (LOOKUP_LAT = 1).
module tb_snoop_response_gen;
   import snoop_response_gen_pkg::*;

   localparam int unsigned Lat = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snp_valid;
   logic        snp_ready;
   logic [1:0]  snp_op;
   logic [31:0] snp_addr;
   logic        tag_rd_en;
   logic [31:0] tag_rd_addr;
   logic        tag_hit;
   logic [3:0]  tag_way;
   logic [1:0]  tag_mesi;
   logic        tag_wr_en;
   logic [3:0]  tag_wr_way;
   logic [1:0]  tag_wr_mesi;
   logic        wb_req;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_addr;
   logic [1:0]  res_result;
   logic        proto_err;
`ifdef SNOOP_STATS_EN
   logic [31:0] snoop_reads, snoop_rwims, snoop_invals, hit_cnt, hitm_cnt, nohit_cnt;
`endif

   snoop_response_gen #(
      .ADDRESS_SIZE (32),
      .INDEX_BITS   (14),
      .OFFSET_BITS  (6),
      .WAYS         (16),
      .LOOKUP_LAT   (Lat)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .snp_valid    (snp_valid),
      .snp_ready    (snp_ready),
      .snp_op       (snp_op),
      .snp_addr     (snp_addr),
      .tag_rd_en    (tag_rd_en),
      .tag_rd_addr  (tag_rd_addr),
      .tag_hit      (tag_hit),
      .tag_way      (tag_way),
      .tag_mesi     (tag_mesi),
      .tag_wr_en    (tag_wr_en),
      .tag_wr_way   (tag_wr_way),
      .tag_wr_mesi  (tag_wr_mesi),
      .wb_req       (wb_req),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_addr     (res_addr),
      .res_result   (res_result),
      .proto_err    (proto_err)
`ifdef SNOOP_STATS_EN
      ,
      .snoop_reads  (snoop_reads),
      .snoop_rwims  (snoop_rwims),
      .snoop_invals (snoop_invals),
      .hit_cnt      (hit_cnt),
      .hitm_cnt     (hitm_cnt),
      .nohit_cnt    (nohit_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          wb_cnt = 0;
   logic [31:0] last_rd_addr = '0;
   logic [3:0]  last_wr_way  = '0;
   logic [1:0]  last_wr_mesi = '0;
   int          rd0, wr0, wb0;

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (tag_rd_en) begin
         rd_cnt       <= rd_cnt + 1;
         last_rd_addr <= tag_rd_addr;
      end
      if (tag_wr_en) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_way  <= tag_wr_way;
         last_wr_mesi <= tag_wr_mesi;
      end
      if (wb_req) wb_cnt <= wb_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic snapshot();
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      wb0 = wb_cnt;
   endtask

   // Present an op and take the acceptance edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                        input logic [3:0] way, input logic [1:0] mesi, input logic keep);
      check("ready_before_issue", {31'd0, snp_ready}, 32'd1);
      tag_hit   = hit;
      tag_way   = way;
      tag_mesi  = mesi;
      snp_op    = op;
      snp_addr  = addr;
      snp_valid = 1'b1;
      snapshot();
      step();
      if (!keep) snp_valid = 1'b0;
   endtask

   task automatic await_result(input string name, input logic [31:0] addr,
                               input logic [1:0] exp_res, input int exp_rd, input int exp_wr,
                               input logic [1:0] exp_wmesi, input logic [3:0] exp_way,
                               input int exp_wb, input int exp_lat);
      int n = 1;
      while (!res_valid && n < 12) begin
         step();
         n++;
      end
      check({name, "_latency"}, n, exp_lat);
      check({name, "_result"}, {30'd0, res_result}, {30'd0, exp_res});
      check({name, "_addr"}, res_addr, addr);
      check({name, "_rd_pulses"}, rd_cnt - rd0, exp_rd);
      check({name, "_wr_pulses"}, wr_cnt - wr0, exp_wr);
      check({name, "_wb_pulses"}, wb_cnt - wb0, exp_wb);
      if (exp_rd != 0) check({name, "_rd_addr"}, last_rd_addr, {addr[31:6], 6'd0});
      if (exp_wr != 0) begin
         check({name, "_wr_mesi"}, {30'd0, last_wr_mesi}, {30'd0, exp_wmesi});
         check({name, "_wr_way"}, {28'd0, last_wr_way}, {28'd0, exp_way});
      end
   endtask

   task automatic handshake(input string name);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({name, "_valid_dropped"}, {31'd0, res_valid}, 32'd0);
      check({name, "_ready_back"}, {31'd0, snp_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      snp_valid = 1'b0;
      snp_op    = BUS_READ;
      snp_addr  = '0;
      tag_hit   = 1'b0;
      tag_way   = '0;
      tag_mesi  = MESI_I;
      res_ready = 1'b0;
      step();
      step();
      check("rst_snp_ready", {31'd0, snp_ready}, 32'd1);
      check("rst_tag_rd_en", {31'd0, tag_rd_en}, 32'd0);
      check("rst_tag_wr_en", {31'd0, tag_wr_en}, 32'd0);
      check("rst_wb_req", {31'd0, wb_req}, 32'd0);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_res_result", {30'd0, res_result}, {30'd0, SNP_NOHIT});
      check("rst_res_addr", res_addr, 32'd0);
      check("rst_proto_err", {31'd0, proto_err}, 32'd0);
      rst_n = 1'b1;
      step();

      issue(BUS_READ, 32'h0000_1040, 1'b1, 4'd3, MESI_M, 1'b0);
      await_result("read_m", 32'h0000_1040, SNP_HITM, 1, 1, MESI_S, 4'd3, 1, Lat + 2);
      handshake("read_m");

      issue(BUS_RWIM, 32'h0FF0_0000, 1'b1, 4'd5, MESI_E, 1'b0);
      await_result("rwim_e", 32'h0FF0_0000, SNP_HIT, 1, 1, MESI_I, 4'd5, 0, Lat + 2);
      handshake("rwim_e");

      issue(BUS_RWIM, 32'h0FF0_0000, 1'b0, 4'd5, MESI_E, 1'b0);
      await_result("rwim_miss", 32'h0FF0_0000, SNP_NOHIT, 1, 0, MESI_I, 4'd0, 0, Lat + 2);
      handshake("rwim_miss");

      issue(BUS_INVALIDATE, 32'h0000_2000, 1'b1, 4'd7, MESI_S, 1'b0);
      await_result("inval_s", 32'h0000_2000, SNP_HIT, 1, 1, MESI_I, 4'd7, 0, Lat + 2);
      check("inval_s_no_err", {31'd0, proto_err}, 32'd0);
      handshake("inval_s");

      issue(BUS_READ, 32'h0000_3000, 1'b1, 4'd1, MESI_S, 1'b0);
      await_result("read_s", 32'h0000_3000, SNP_HIT, 1, 0, MESI_S, 4'd0, 0, Lat + 2);
      handshake("read_s");

      issue(BUS_READ, 32'h0000_4000, 1'b1, 4'd1, MESI_I, 1'b0);
      await_result("read_hit_i", 32'h0000_4000, SNP_NOHIT, 1, 0, MESI_I, 4'd0, 0, Lat + 2);
      handshake("read_hit_i");

      issue(BUS_INVALIDATE, 32'h0000_5000, 1'b1, 4'd4, MESI_M, 1'b0);
      await_result("inval_m", 32'h0000_5000, SNP_NOHIT, 1, 0, MESI_I, 4'd0, 0, Lat + 2);
      check("inval_m_err", {31'd0, proto_err}, 32'd1);
      handshake("inval_m");

      issue(BUS_WRITE, 32'h1234_5678, 1'b1, 4'd2, MESI_M, 1'b0);
      await_result("write", 32'h1234_5678, SNP_NOHIT, 0, 0, MESI_I, 4'd0, 0, 2);
      check("write_err_sticky", {31'd0, proto_err}, 32'd1);
      handshake("write");

      // Stall the reporter with the next op already waiting on the bus.
      issue(BUS_READ, 32'h2000_0080, 1'b1, 4'd2, MESI_E, 1'b1);
      snp_op   = BUS_RWIM;
      snp_addr = 32'h3000_0000;
      await_result("stall_e", 32'h2000_0080, SNP_HIT, 1, 1, MESI_S, 4'd2, 0, Lat + 2);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", {31'd0, res_valid}, 32'd1);
         check("stall_result", {30'd0, res_result}, {30'd0, SNP_HIT});
         check("stall_addr", res_addr, 32'h2000_0080);
         check("stall_ready_low", {31'd0, snp_ready}, 32'd0);
      end
      tag_way  = 4'd9;
      tag_mesi = MESI_M;
      snapshot();
      handshake("stall");
      step();
      snp_valid = 1'b0;
      check("b2b_accepted", {31'd0, snp_ready}, 32'd0);
      await_result("b2b_rwim_m", 32'h3000_0000, SNP_HITM, 1, 1, MESI_I, 4'd9, 1, Lat + 2);
      check("b2b_err_sticky", {31'd0, proto_err}, 32'd1);
      handshake("b2b");

      // Reset while a result is pending.
      issue(BUS_RWIM, 32'h4000_0040, 1'b1, 4'd1, MESI_S, 1'b0);
      await_result("rwim_s", 32'h4000_0040, SNP_HIT, 1, 1, MESI_I, 4'd1, 0, Lat + 2);
      rst_n = 1'b0;
      snapshot();
      step();
      check("rpt_rst_valid", {31'd0, res_valid}, 32'd0);
      check("rpt_rst_ready", {31'd0, snp_ready}, 32'd1);
      check("rpt_rst_result", {30'd0, res_result}, {30'd0, SNP_NOHIT});
      check("rpt_rst_err", {31'd0, proto_err}, 32'd0);
      rst_n = 1'b1;
      step();
      step();
      check("rpt_rst_no_wr", wr_cnt - wr0, 32'd0);
      check("rpt_rst_no_wb", wb_cnt - wb0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
